// File: rtl/moddiv_pkg.sv
// Shared types for the modular-division datapath: 16-bit residues and the
// stage-1 register bundle of the pipelined modular adder.
package moddiv_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [WORD_W:0] t;
        word_t           p;
        logic            sub;
        logic            e;
    } s1_reg_t;

endpackage

// File: rtl/BCLA_ADD_16.sv
// 16-bit block carry-lookahead adder: four 4-bit groups with a second-level
// lookahead across the group generate/propagate signals.
module BCLA_ADD_16 (
    output logic [15:0] sum,
    output logic        c_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in
);

    logic [15:0] g;
    logic [15:0] pr;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        pr = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (pr[4*k+3] & g[4*k+2])
                  | (pr[4*k+3] & pr[4*k+2] & g[4*k+1])
                  | (pr[4*k+3] & pr[4*k+2] & pr[4*k+1] & g[4*k]);
            gp[k] = &pr[4*k +: 4];
        end

        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (pr[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (pr[4*k+1] & g[4*k])
                     | (pr[4*k+1] & pr[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (pr[4*k+2] & g[4*k+1])
                     | (pr[4*k+2] & pr[4*k+1] & g[4*k])
                     | (pr[4*k+2] & pr[4*k+1] & pr[4*k] & gc[k]);
        end

        sum   = pr ^ c;
        c_out = gc[4];
    end

endmodule

// File: rtl/mod_add_16.sv
// Two-stage pipelined (a +/- b) mod p for 16-bit residues with valid/ready on
// both sides; operand errors yield r = 0 with err set.
module mod_add_16
    import moddiv_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             err
);

    s1_reg_t s1_q;
    s1_reg_t s1_d;
    logic    s1_v;
    logic    en1;
    logic    en2;

    word_t   b_op;
    word_t   s1_sum;
    logic    s1_cout;

    word_t   p_op;
    word_t   s2_sum;
    logic    s2_cout;
    word_t   r_next;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_v || en2;
    assign in_ready = en1;

    assign b_op = sub ? ~b : b;

    BCLA_ADD_16 u_s1_add (
        .sum   (s1_sum),
        .c_out (s1_cout),
        .a     (a),
        .b     (b_op),
        .c_in  (sub)
    );

    always_comb begin
        s1_d     = '0;
        s1_d.t   = {s1_cout, s1_sum};
        s1_d.p   = p;
        s1_d.sub = sub;
        s1_d.e   = (a >= p) || (b >= p) || (p == '0);
    end

    // One adder serves both folds: t - p for add (c_in=1, ~p) and t + p for sub.
    assign p_op = s1_q.sub ? s1_q.p : ~s1_q.p;

    BCLA_ADD_16 u_s2_fold (
        .sum   (s2_sum),
        .c_out (s2_cout),
        .a     (s1_q.t[WORD_W-1:0]),
        .b     (p_op),
        .c_in  (!s1_q.sub)
    );

    always_comb begin
        r_next = s1_q.t[WORD_W-1:0];
        if (s1_q.e) begin
            r_next = '0;
        end else if (s1_q.sub) begin
            if (!s1_q.t[WORD_W]) r_next = s2_sum;
        end else begin
            // t >= p over 17 bits: either t overflowed 16 bits or t[15:0]-p had no borrow
            if (s1_q.t[WORD_W] || s2_cout) r_next = s2_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (en1) begin
            s1_v <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            r         <= '0;
            err       <= 1'b0;
        end else if (en2) begin
            out_valid <= s1_v;
            if (s1_v) begin
                r   <= r_next;
                err <= s1_q.e;
            end
        end
    end

endmodule

// File: tb/tb_mod_add_16.sv
// Self-checking bench for mod_add_16: directed vector table, backpressure and
// reset sequences, and a randomized stream against a plain-arithmetic model.
module tb_mod_add_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        err;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int a;
        int b;
        int p;
        bit sub;
        int exp_r;
        bit exp_err;
    } vec_t;

    typedef struct {
        int r;
        bit e;
    } res_t;

    mod_add_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .p         (p),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic res_t model(input int ma, input int mb, input int mp, input bit msub);
        res_t res;
        if (ma >= mp || mb >= mp || mp == 0) begin
            res.r = 0;
            res.e = 1'b1;
        end else begin
            res.e = 1'b0;
            res.r = msub ? (ma - mb + mp) % mp : (ma + mb) % mp;
        end
        return res;
    endfunction

    task automatic drive(input vec_t v);
        a   = v.a[15:0];
        b   = v.b[15:0];
        p   = v.p[15:0];
        sub = v.sub;
    endtask

    // Single transaction on an idle pipeline: checks latency, r and err.
    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        chk({name, "_latency"}, cyc, 2);
        chk({name, "_r"}, r, v.exp_r);
        chk({name, "_err"}, err, v.exp_err);
    endtask

    vec_t vecs[9];
    vec_t bp[4];
    int   bp_exp[4];
    res_t q[$];

    initial begin
        int   acc;
        int   sent;
        int   rcv;
        bit   have;
        bit   prev_stall;
        int   prev_r;
        int   got[$];
        vec_t cur;
        res_t m;
        res_t exp_res;

        vecs[0] = '{126,   218,   65521, 1'b0, 344,   1'b0};
        vecs[1] = '{65520, 10,    65521, 1'b0, 9,     1'b0};
        vecs[2] = '{5,     7,     65521, 1'b1, 65519, 1'b0};
        vecs[3] = '{7,     5,     65521, 1'b1, 2,     1'b0};
        vecs[4] = '{1000,  1,     1000,  1'b0, 0,     1'b1};
        vecs[5] = '{3,     4,     0,     1'b0, 0,     1'b1};
        vecs[6] = '{0,     0,     1,     1'b1, 0,     1'b0};
        vecs[7] = '{65534, 65534, 65535, 1'b0, 65533, 1'b0};
        vecs[8] = '{0,     65534, 65535, 1'b1, 1,     1'b0};

        bp[0] = '{1,  2,  97, 1'b0, 0, 1'b0};
        bp[1] = '{3,  4,  97, 1'b0, 0, 1'b0};
        bp[2] = '{50, 60, 97, 1'b0, 0, 1'b0};
        bp[3] = '{96, 96, 97, 1'b0, 0, 1'b0};
        bp_exp = '{3, 7, 13, 95};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; p = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_r", r, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: four adds with the consumer stalled.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (acc < 4) begin
                drive(bp[acc]);
                in_valid = 1'b1;
            end
            #1;
            if (cyc >= 2) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_r", r, 3);
            end
            if (in_valid && in_ready) acc++;
        end
        chk("bp_accepts", acc, 2);
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 4) begin
                drive(bp[acc]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 0) chk("bp_no_bubble", in_ready, 1);
            if (out_valid) got.push_back(int'(r));
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("bp_order%0d", i), got[i], bp_exp[i]);

        // Randomized stream with random valid/ready on both sides.
        repeat (3) @(negedge clk);
        sent = 0;
        rcv = 0;
        have = 1'b0;
        prev_stall = 1'b0;
        prev_r = 0;
        for (int cyc = 0; cyc < 3000 && rcv < 100; cyc++) begin
            @(negedge clk);
            if (!have && sent < 100) begin
                cur.p = ($urandom % 16 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 65535));
                cur.a = (cur.p > 0 && $urandom % 16 != 0) ? int'($urandom % cur.p) : int'($urandom_range(0, 65535));
                cur.b = (cur.p > 0) ? int'($urandom % cur.p) : int'($urandom_range(0, 65535));
                cur.sub = $urandom % 2;
                have = 1'b1;
            end
            drive(cur);
            in_valid  = have && ($urandom % 4 != 0);
            out_ready = ($urandom % 4 != 0);
            #1;
            if (prev_stall) begin
                chk("rnd_stall_valid", out_valid, 1);
                chk("rnd_stall_r", r, prev_r);
            end
            prev_stall = out_valid && !out_ready;
            prev_r = r;
            if (out_valid && out_ready) begin
                chk("rnd_expected_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_res = q.pop_front();
                    chk($sformatf("rnd_r%0d", rcv), r, exp_res.r);
                    chk($sformatf("rnd_err%0d", rcv), err, exp_res.e);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                m = model(cur.a, cur.b, cur.p, cur.sub);
                q.push_back(m);
                sent++;
                have = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("rnd_sent", sent, 100);
        chk("rnd_received", rcv, 100);
        chk("rnd_leftover", q.size(), 0);

        // Reset with two operations in flight.
        @(negedge clk);
        out_ready = 1'b0;
        cur = '{100, 50, 1000, 1'b0, 0, 1'b0};
        drive(cur);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_valid_before", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_r", r, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_stale", out_valid, 0);
        end
        run_vec(vecs[0], "mid_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mod_add_16.md
# mod_add_16

Two-stage pipelined modular adder/subtractor for 16-bit residues, with valid/ready handshake on both sides. It sits directly downstream of the 16-bit block carry-lookahead adder `BCLA_ADD_16` and wraps it. It folds the raw 17-bit sum or difference back into the range [0, p), which is the operation the modular-division datapath needs every step. Throughput is one operation per cycle, and latency is 2 cycles.

## Interface
Parameters:
- `WIDTH`, 16: operand/modulus width; the `BCLA_ADD_16` instances fix it at 16, other values unsupported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block accepts operands this cycle.
- `a` in 16: operand A, residue.
- `b` in 16: operand B, residue.
- `p` in 16: modulus, sampled with the operands per transaction.
- `sub` in 1: operation select; 0 gives (a+b) mod p, 1 gives (a−b) mod p.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `r` out 16: result.
- `err` out 1: operand error flag for this result.

## Operation
- Transfer on an input edge when `in_valid && in_ready`; transfer on an output edge when `out_valid && out_ready`.
- Stage 1 (S1):
  - t[16:0] = {c_out, sum} of `BCLA_ADD_16`(a, sub ? ~b : b, c_in = sub).
  - Registers t, p, sub and e = (a ≥ p) | (b ≥ p) | (p == 0).
- Stage 2 (S2):
  - Add: u = t − p over 17 bits. r = u[15:0] if t ≥ p, else t[15:0].
  - Sub: t[16] = 1 means no borrow (a ≥ b), so r = t[15:0]. t[16] = 0 means a < b, so r = t[15:0] + p, truncated to 16 bits.
  - Registers r, err = e, out_valid.
- Error: if e = 1, then r = 0 and err = 1. Result ordering and handshake are unchanged.
- Invariant: if e = 0, then r < p.
- Pipeline enables:
  - en2 = !s2_v | out_ready.
  - en1 = !s1_v | en2.
  - `in_ready` = en1, combinational from registered state and `out_ready` only. It has no path from `in_valid`.
- While `out_valid && !out_ready`, `r`, `err` and `out_valid` hold stable.
- No control FSM. Each stage's valid bit is its state: empty/full per stage, four combinations, all legal.

## Timing
- Reset values: `out_valid` = 0, `r` = 0, `err` = 0, s1_v = 0, all datapath registers 0. `in_ready` = 1 while `rst` is low after reset.
- Latency: an operation accepted at edge k gives `out_valid` = 1 after edge k+1, presentable at edge k+2 when there are no stalls.
- Full: S1 and S2 both valid and `out_ready` = 0 forces `in_ready` = 0. At most 2 results are buffered.
- Simultaneous output pop and input push with both stages full is permitted with no bubble (`in_ready` = 1 when `out_ready` = 1).
- Reset asserted mid-operation discards all in-flight results and returns outputs to reset values immediately. No result is produced for transactions in flight at reset.
- Wrap-around:
  - Add with t up to 2p−2 < 2^17 never overflows 17 bits.
  - Sub correction (t[15:0] + p) wraps modulo 2^16 by design.

## Structure
- Shared package `moddiv_pkg`:
  - `WORD_W` = 16.
  - typedef `word_t`.
  - typedef `s1_reg_t` (t, p, sub, e).
- Sub-module reused: `BCLA_ADD_16` (port order sum, c_out, a, b, c_in).
  - One instance in S1 for the add/sub.
  - A second instance in S2 computes t[15:0] + (sub ? p : ~p) with c_in = !sub. This gives both u and the sub correction.
- No new sub-module is needed.

## Test plan
- Reset then p=65521, add a=126, b=218 → r=344, err=0, `out_valid` 2 cycles after accept.
- Add wrap: p=65521, a=65520, b=10 → r=9. Sub: a=5, b=7 → r=65519. Sub: a=7, b=5 → r=2.
- Error: p=1000, a=1000, b=1 → r=0, err=1. p=0 with any operands → err=1.
- Backpressure: 4 back-to-back adds (p=97: 1+2, 3+4, 50+60, 96+96), `out_ready`=0 for 3 cycles.
  - `in_ready` drops after 2 accepts.
  - Results then pop in order: 3, 7, 13, 95.
  - `r` stays stable while stalled.
- Full-throughput stream: 100 random in-range ops with random `out_ready` and `in_valid`. Compare against a reference model ((a±b) mod p): no drops, no duplicates, order kept.
- Reset mid-flight: accept 2 ops, assert `rst` for 1 cycle before the first pops.
  - `out_valid` = 0 and `r` = 0 immediately.
  - No stale result after release.
  - A new op (add 126+218, p=65521) gives 344.
